// File: rtl/bht_predictor_if.sv
// Core-to-predictor bundle for bht_predictor: IF lookup, MEM resolution and the
// tracked-branch/flush status returned to the pipeline.
interface bht_predictor_if;
    logic [31:0] pc;
    logic        is_branch;
    logic        stall;
    logic        PCSrc;
    logic        is_taken;
    logic [31:0] mem_pc;
    logic        mem_valid;
    logic        miss_predict;
    logic        flush;

    modport master (
        output pc, is_branch, stall, PCSrc,
        input  is_taken, mem_pc, mem_valid, miss_predict, flush
    );

    modport slave (
        input  pc, is_branch, stall, PCSrc,
        output is_taken, mem_pc, mem_valid, miss_predict, flush
    );
endinterface

// File: rtl/bht_predictor.sv
// Bimodal branch history table (2-bit counters indexed by pc[9:2]) with an
// ID/EX/MEM tracking pipe. Optional macro BHT_BYPASS_EN forwards same-cycle updates.
module bht_predictor #(
    parameter int NUM_ENTRIES = 256,
    parameter int PIPE_DEPTH  = 3
) (
    input  logic           clk,
    input  logic           rst_i,
    bht_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    if (PIPE_DEPTH != 3) begin : g_depth_check
        $error("bht_predictor supports only PIPE_DEPTH == 3");
    end

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred;
    } stage_t;

    stage_t id_q, id_d;
    stage_t ex_q, ex_d;
    stage_t mem_q, mem_d;

    logic [1:0] cnt_q [NUM_ENTRIES];
    logic [1:0] cnt_d [NUM_ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_cur;
    logic [1:0]       upd_val;
    logic [1:0]       lookup_ctr;
    logic             resolve;
    logic             flush_w;
    logic             miss_w;
    logic             is_taken_w;

    assign if_idx  = bus.pc[IDX_W+1:2];
    assign upd_idx = mem_q.pc[IDX_W+1:2];
    assign resolve = mem_q.valid & ~bus.stall;
    assign flush_w = resolve & (mem_q.pred != bus.PCSrc);
    assign miss_w  = resolve & mem_q.pred & ~bus.PCSrc;

    // Saturating counter step for the resolving branch.
    always_comb begin
        upd_cur = cnt_q[upd_idx];
        upd_val = upd_cur;
        if (bus.PCSrc) begin
            if (upd_cur != 2'b11) upd_val = upd_cur + 2'd1;
        end else begin
            if (upd_cur != 2'b00) upd_val = upd_cur - 2'd1;
        end
    end

    always_comb begin
        // NOTE: default every comb output first so no path leaves it unassigned (no latch).
        lookup_ctr = cnt_q[if_idx];
`ifdef BHT_BYPASS_EN
        if (resolve && (upd_idx == if_idx)) lookup_ctr = upd_val;
`endif
        is_taken_w = bus.is_branch & (lookup_ctr >= 2'b10);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (resolve) cnt_d[upd_idx] = upd_val;
    end

    // Stall freezes everything; a flush squashes wrong-path entries in place.
    always_comb begin
        id_d  = id_q;
        ex_d  = ex_q;
        mem_d = mem_q;
        if (!bus.stall) begin
            if (flush_w) begin
                id_d.valid  = 1'b0;
                ex_d.valid  = 1'b0;
                mem_d.valid = 1'b0;
            end else begin
                id_d  = '{valid: bus.is_branch, pc: bus.pc, pred: is_taken_w};
                ex_d  = id_q;
                mem_d = ex_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            // NOTE: non-blocking for all state; the table is reset because every
            // counter must read weakly-not-taken one cycle after reset.
            id_q  <= '0;
            ex_q  <= '0;
            mem_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) cnt_q[i] <= 2'b01;
        end else begin
            id_q  <= id_d;
            ex_q  <= ex_d;
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.is_taken     = is_taken_w;
    assign bus.mem_pc       = mem_q.pc;
    assign bus.mem_valid    = mem_q.valid;
    assign bus.miss_predict = miss_w;
    assign bus.flush        = flush_w;
endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: reset, saturation, mispredict squash, stall,
// same-index collision (both builds) and reset of an in-flight branch.
module tb_bht_predictor;
    localparam logic [31:0] IDLE_PC = 32'h0000_03FC;

    logic clk = 1'b0;
    logic rst_i;
    int   checks   = 0;
    int   failures = 0;

    bht_predictor_if bus();

    bht_predictor dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p_pc, input logic br, input logic st, input logic src);
        bus.pc        = p_pc;
        bus.is_branch = br;
        bus.stall     = st;
        bus.PCSrc     = src;
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(IDLE_PC, 1'b0, 1'b0, 1'b0);
        tick();
        rst_i = 1'b0;
    endtask

    // One isolated branch: lookup in cycle N, resolution in cycle N+3.
    task automatic run_branch(input string tag, input logic [31:0] p_pc,
                              input logic src, input logic exp_pred);
        drive(p_pc, 1'b1, 1'b0, 1'b0);
        check({tag, "_pred"}, bus.is_taken, exp_pred);
        tick();
        drive(IDLE_PC, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(IDLE_PC, 1'b0, 1'b0, src);
        check({tag, "_mem_valid"}, bus.mem_valid, 1'b1);
        check({tag, "_mem_pc"}, bus.mem_pc, p_pc);
        check({tag, "_flush"}, bus.flush, exp_pred != src);
        check({tag, "_miss"}, bus.miss_predict, exp_pred & ~src);
        tick();
        drive(IDLE_PC, 1'b0, 1'b0, 1'b0);
        check({tag, "_after_valid"}, bus.mem_valid, 1'b0);
    endtask

    initial begin
        rst_i = 1'b1;
        drive(IDLE_PC, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state; PCSrc with nothing in MEM must be ignored.
        drive(32'h40, 1'b1, 1'b0, 1'b1);
        check("rst_mem_valid", bus.mem_valid, 1'b0);
        check("rst_mem_pc", bus.mem_pc, 32'h0);
        check("rst_flush", bus.flush, 1'b0);
        check("rst_miss", bus.miss_predict, 1'b0);
        check("rst_is_taken", bus.is_taken, 1'b0);
        drive(IDLE_PC, 1'b0, 1'b0, 1'b0);

        // Saturation at 0x40: 01 -> 10 -> 11 -> 11, then one not-taken -> 10.
        run_branch("s1_a", 32'h40, 1'b1, 1'b0);
        run_branch("s1_b", 32'h40, 1'b1, 1'b1);
        run_branch("s1_c", 32'h40, 1'b1, 1'b1);
        run_branch("s1_sat", 32'h40, 1'b0, 1'b1);
        drive(32'h40, 1'b1, 1'b0, 1'b0);
        check("s1_final", bus.is_taken, 1'b1);
        drive(32'h40, 1'b0, 1'b0, 1'b0);
        check("s1_not_branch", bus.is_taken, 1'b0);

        // Not-taken mispredict at 0xC0: 01 resolved taken -> 10.
        run_branch("s3", 32'hC0, 1'b1, 1'b0);
        drive(32'hC0, 1'b1, 1'b0, 1'b0);
        check("s3_after", bus.is_taken, 1'b1);

        // Mispredict at 0x80 (counter 10) with two younger branches in flight.
        run_branch("s2_warm", 32'h80, 1'b1, 1'b0);
        drive(32'h80, 1'b1, 1'b0, 1'b0);
        check("s2_pred", bus.is_taken, 1'b1);
        tick();
        drive(32'h100, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h180, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h200, 1'b1, 1'b0, 1'b0);
        check("s2_mem_pc", bus.mem_pc, 32'h80);
        check("s2_miss", bus.miss_predict, 1'b1);
        check("s2_flush", bus.flush, 1'b1);
        tick();
        drive(IDLE_PC, 1'b0, 1'b0, 1'b1);
        check("s2_n4_valid", bus.mem_valid, 1'b0);
        check("s2_n4_flush", bus.flush, 1'b0);
        check("s2_n4_miss", bus.miss_predict, 1'b0);
        tick();
        check("s2_n5_valid", bus.mem_valid, 1'b0);
        tick();
        check("s2_n6_valid", bus.mem_valid, 1'b0);
        drive(32'h80, 1'b1, 1'b0, 1'b0);
        check("s2_counter", bus.is_taken, 1'b0);
        drive(IDLE_PC, 1'b0, 1'b0, 1'b0);

        // Stall for two cycles while 0x140 sits in EX, then once more in MEM.
        drive(32'h140, 1'b1, 1'b0, 1'b0);
        check("s4_pred", bus.is_taken, 1'b0);
        tick();
        drive(IDLE_PC, 1'b0, 1'b0, 1'b0);
        tick();
        drive(IDLE_PC, 1'b0, 1'b1, 1'b1);
        check("s4_n2_valid", bus.mem_valid, 1'b0);
        tick();
        drive(IDLE_PC, 1'b0, 1'b1, 1'b1);
        check("s4_n3_valid", bus.mem_valid, 1'b0);
        tick();
        drive(IDLE_PC, 1'b0, 1'b0, 1'b1);
        check("s4_n4_valid", bus.mem_valid, 1'b0);
        check("s4_n4_flush", bus.flush, 1'b0);
        tick();
        drive(IDLE_PC, 1'b0, 1'b1, 1'b1);
        check("s4_n5_valid", bus.mem_valid, 1'b1);
        check("s4_n5_mem_pc", bus.mem_pc, 32'h140);
        check("s4_stall_flush", bus.flush, 1'b0);
        check("s4_stall_miss", bus.miss_predict, 1'b0);
        tick();
        drive(IDLE_PC, 1'b0, 1'b0, 1'b1);
        check("s4_n6_valid", bus.mem_valid, 1'b1);
        check("s4_n6_flush", bus.flush, 1'b1);
        check("s4_n6_miss", bus.miss_predict, 1'b0);
        tick();
        drive(IDLE_PC, 1'b0, 1'b0, 1'b0);
        check("s4_drained", bus.mem_valid, 1'b0);
        drive(32'h140, 1'b1, 1'b0, 1'b0);
        check("s4_counter", bus.is_taken, 1'b1);
        drive(IDLE_PC, 1'b0, 1'b0, 1'b0);
        run_branch("s4_once", 32'h140, 1'b0, 1'b1);
        drive(32'h140, 1'b1, 1'b0, 1'b0);
        check("s4_single_update", bus.is_taken, 1'b0);

        // A non-branch reaching MEM must not touch the counter at 0xC0 (10).
        drive(32'hC0, 1'b0, 1'b0, 1'b0);
        check("inv_is_taken", bus.is_taken, 1'b0);
        tick();
        drive(IDLE_PC, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("inv_mem_valid", bus.mem_valid, 1'b0);
        check("inv_flush", bus.flush, 1'b0);
        tick();
        drive(32'hC0, 1'b1, 1'b0, 1'b0);
        check("inv_counter", bus.is_taken, 1'b1);

        // Same-index collision at index 0x10: update 01 -> 10 while IF looks up 0x40.
        do_reset();
        drive(32'h40, 1'b1, 1'b0, 1'b0);
        check("s5_pred", bus.is_taken, 1'b0);
        tick();
        drive(IDLE_PC, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(32'h40, 1'b1, 1'b0, 1'b1);
        check("s5_flush", bus.flush, 1'b1);
`ifdef BHT_BYPASS_EN
        check("s5_collision", bus.is_taken, 1'b1);
`else
        check("s5_collision", bus.is_taken, 1'b0);
`endif
        tick();
        drive(32'h40, 1'b1, 1'b0, 1'b0);
        check("s5_after", bus.is_taken, 1'b1);

        // Reset while 0x40 (counter 10, predicted taken) sits in EX.
        tick();
        drive(IDLE_PC, 1'b0, 1'b0, 1'b0);
        tick();
        rst_i = 1'b1;
        drive(IDLE_PC, 1'b0, 1'b1, 1'b1);
        tick();
        rst_i = 1'b0;
        drive(IDLE_PC, 1'b0, 1'b0, 1'b0);
        check("s6_n3_valid", bus.mem_valid, 1'b0);
        check("s6_n3_flush", bus.flush, 1'b0);
        tick();
        check("s6_n4_valid", bus.mem_valid, 1'b0);
        tick();
        check("s6_n5_valid", bus.mem_valid, 1'b0);
        drive(32'h40, 1'b1, 1'b0, 1'b0);
        check("s6_counter", bus.is_taken, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
